// File: rtl/ahb_slave_interface.sv
// AHB front end of the AHB-to-APB bridge: qualifies transfers, decodes slave, pipelines addr/data, answers unmapped accesses with ERROR.
// Latency: valid/tempselx combinational in the address phase; Haddr1/Hwdata1/Hwritereg one cycle later; ERROR starts the cycle after.
// Backpressure: pipeline registers advance only while Hreadyin=1; the first ERROR cycle pulls Hready_err low to stall the master.
module ahb_slave_interface #(
   parameter logic [31:0] BASE0       = 32'h8000_0000,
   parameter logic [31:0] BASE1       = 32'h8400_0000,
   parameter logic [31:0] BASE2       = 32'h8800_0000,
   parameter int          REGION_BITS = 26,
   parameter int          ERRCNT_W    = 8
) (
   input  logic                Hclk,
   input  logic                Hreset,
   input  logic                Hwrite,
   input  logic                Hreadyin,
   input  logic [1:0]          Htrans,
   input  logic [31:0]         Haddr,
   input  logic [31:0]         Hwdata,
   input  logic [31:0]         Prdata,
   output logic                valid,
   output logic [2:0]          tempselx,
   output logic [31:0]         Haddr1,
   output logic [31:0]         Haddr2,
   output logic [31:0]         Hwdata1,
   output logic [31:0]         Hwdata2,
   output logic                Hwritereg,
   output logic [31:0]         Hrdata,
   output logic [1:0]          Hresp,
   output logic                Hready_err,
   output logic [ERRCNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {
      E_IDLE = 2'd0,
      E_ERR1 = 2'd1,
      E_ERR2 = 2'd2
   } err_state_t;

   localparam logic [ERRCNT_W-1:0] CNT_ONE = {{(ERRCNT_W-1){1'b0}}, 1'b1};

   err_state_t          err_state_q, err_state_d;
   logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [31:0]         haddr1_q, haddr1_d, haddr2_q, haddr2_d;
   logic [31:0]         hwdata1_q, hwdata1_d, hwdata2_q, hwdata2_d;
   logic                hwritereg_q, hwritereg_d;
   logic                active;
   logic                unmapped;
   // HTRANS[0] only separates IDLE/BUSY and NONSEQ/SEQ, which are treated alike here.
   logic                unused_htrans0;

   assign unused_htrans0 = Htrans[0];

   // Region decode on the upper address bits: each region is 2^REGION_BITS bytes starting at its base.
   always_comb begin
      tempselx = 3'b000;
      if (Haddr[31:REGION_BITS] == BASE0[31:REGION_BITS])
         tempselx = 3'b001;
      else if (Haddr[31:REGION_BITS] == BASE1[31:REGION_BITS])
         tempselx = 3'b010;
      else if (Haddr[31:REGION_BITS] == BASE2[31:REGION_BITS])
         tempselx = 3'b100;
   end

   // NONSEQ/SEQ with the bus ready is a real transfer; valid is suppressed while an error is being answered.
   always_comb begin
      active   = Hreadyin & Htrans[1];
      unmapped = active & (tempselx == 3'b000);
      valid    = active & (tempselx != 3'b000) & (err_state_q == E_IDLE) & ~Hreset;
   end

   // Address/data/direction pipeline advances only on accepted bus cycles.
   always_comb begin
      haddr1_d    = haddr1_q;
      haddr2_d    = haddr2_q;
      hwdata1_d   = hwdata1_q;
      hwdata2_d   = hwdata2_q;
      hwritereg_d = hwritereg_q;
      if (Hreadyin) begin
         haddr1_d    = Haddr;
         haddr2_d    = haddr1_q;
         hwdata1_d   = Hwdata;
         hwdata2_d   = hwdata1_q;
         hwritereg_d = Hwrite;
      end
   end

   // Error sequencer: an unmapped transfer in E_IDLE starts the two-cycle ERROR; one seen in E_ERR2 is dropped.
   always_comb begin
      err_state_d = err_state_q;
      err_cnt_d   = err_cnt_q;
      case (err_state_q)
         E_IDLE: begin
            if (unmapped) begin
               err_state_d = E_ERR1;
               if (err_cnt_q != {ERRCNT_W{1'b1}})
                  err_cnt_d = err_cnt_q + CNT_ONE;
            end
         end
         E_ERR1:  err_state_d = E_ERR2;
         E_ERR2:  err_state_d = E_IDLE;
         default: err_state_d = E_IDLE;
      endcase
   end

   // Response outputs come only from the registered state, keeping Haddr off the HRESP/HREADY path.
   always_comb begin
      Hresp      = 2'b00;
      Hready_err = 1'b1;
      case (err_state_q)
         E_ERR1: begin
            Hresp      = 2'b01;
            Hready_err = 1'b0;
         end
         E_ERR2:  Hresp = 2'b01;
         default: ;
      endcase
   end

   // State registers; reset clears everything, including an error in flight.
   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         err_state_q <= E_IDLE;
         err_cnt_q   <= '0;
         haddr1_q    <= '0;
         haddr2_q    <= '0;
         hwdata1_q   <= '0;
         hwdata2_q   <= '0;
         hwritereg_q <= 1'b0;
      end else begin
         err_state_q <= err_state_d;
         err_cnt_q   <= err_cnt_d;
         haddr1_q    <= haddr1_d;
         haddr2_q    <= haddr2_d;
         hwdata1_q   <= hwdata1_d;
         hwdata2_q   <= hwdata2_d;
         hwritereg_q <= hwritereg_d;
      end
   end

   assign Haddr1    = haddr1_q;
   assign Haddr2    = haddr2_q;
   assign Hwdata1   = hwdata1_q;
   assign Hwdata2   = hwdata2_q;
   assign Hwritereg = hwritereg_q;
   assign err_cnt   = err_cnt_q;
   assign Hrdata    = Prdata;

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Testbench for ahb_slave_interface: directed scenarios plus randomised traffic around region boundaries.
// Each cycle the expected outputs are pushed to a scoreboard when inputs are driven, then popped and compared.
// Inputs change on the falling edge; outputs are sampled 1 ns later, away from the rising edge.
module tb_ahb_slave_interface;

   localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

   logic        Hclk = 1'b0;
   logic        Hreset, Hwrite, Hreadyin;
   logic [1:0]  Htrans;
   logic [31:0] Haddr, Hwdata, Prdata;
   logic        valid, Hwritereg, Hready_err;
   logic [2:0]  tempselx;
   logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2, Hrdata;
   logic [1:0]  Hresp;
   logic [7:0]  err_cnt;

   ahb_slave_interface dut (
      .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin), .Htrans(Htrans),
      .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata), .valid(valid), .tempselx(tempselx),
      .Haddr1(Haddr1), .Haddr2(Haddr2), .Hwdata1(Hwdata1), .Hwdata2(Hwdata2),
      .Hwritereg(Hwritereg), .Hrdata(Hrdata), .Hresp(Hresp), .Hready_err(Hready_err),
      .err_cnt(err_cnt)
   );

   always #5 Hclk = ~Hclk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic        valid;
      logic [2:0]  sel;
      logic [31:0] a1, a2, d1, d2, rdata;
      logic        wr;
      logic [1:0]  resp;
      logic        rdy;
      logic [7:0]  cnt;
   } exp_t;

   exp_t sb[$];

   // Reference model state
   logic [31:0] m_a1, m_a2, m_d1, m_d2;
   logic        m_wr;
   int          m_st;    // 0 idle, 1 first error cycle, 2 second error cycle
   logic [7:0]  m_cnt;

   function automatic logic [2:0] ref_sel(input logic [31:0] a);
      if (a >= 32'h8000_0000 && a < 32'h8400_0000) return 3'b001;
      if (a >= 32'h8400_0000 && a < 32'h8800_0000) return 3'b010;
      if (a >= 32'h8800_0000 && a < 32'h8C00_0000) return 3'b100;
      return 3'b000;
   endfunction

   task automatic model_reset();
      m_a1 = 0; m_a2 = 0; m_d1 = 0; m_d2 = 0; m_wr = 0; m_st = 0; m_cnt = 0;
   endtask

   task automatic push_exp();
      exp_t e;
      logic act;
      act     = Hreadyin && Htrans[1];
      e.sel   = ref_sel(Haddr);
      e.valid = act && (e.sel != 3'b000) && (m_st == 0) && !Hreset;
      e.a1 = m_a1; e.a2 = m_a2; e.d1 = m_d1; e.d2 = m_d2; e.wr = m_wr;
      e.resp  = (m_st == 0) ? 2'b00 : 2'b01;
      e.rdy   = (m_st != 1);
      e.cnt   = m_cnt;
      e.rdata = Prdata;
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      chk("valid", {31'd0, valid}, {31'd0, e.valid});
      chk("tempselx", {29'd0, tempselx}, {29'd0, e.sel});
      chk("Haddr1", Haddr1, e.a1);
      chk("Haddr2", Haddr2, e.a2);
      chk("Hwdata1", Hwdata1, e.d1);
      chk("Hwdata2", Hwdata2, e.d2);
      chk("Hwritereg", {31'd0, Hwritereg}, {31'd0, e.wr});
      chk("Hresp", {30'd0, Hresp}, {30'd0, e.resp});
      chk("Hready_err", {31'd0, Hready_err}, {31'd0, e.rdy});
      chk("err_cnt", {24'd0, err_cnt}, {24'd0, e.cnt});
      chk("Hrdata", Hrdata, e.rdata);
   endtask

   // Advance the model across one rising edge using the inputs held through it.
   task automatic model_edge();
      logic act;
      if (Hreset) return;
      act = Hreadyin && Htrans[1];
      case (m_st)
         0: if (act && ref_sel(Haddr) == 3'b000) begin
               m_st = 1;
               if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            end
         1: m_st = 2;
         default: m_st = 0;
      endcase
      if (Hreadyin) begin
         m_a2 = m_a1; m_a1 = Haddr;
         m_d2 = m_d1; m_d1 = Hwdata;
         m_wr = Hwrite;
      end
   endtask

   task automatic cycle(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic rdy);
      @(negedge Hclk);
      Htrans = tr; Hwrite = wr; Haddr = a; Hwdata = d; Hreadyin = rdy;
      Prdata = $urandom;
      #1;
      push_exp();
      check_out();
      @(posedge Hclk);
      model_edge();
   endtask

   // Assert reset asynchronously mid-cycle, check its immediate effect, release after one edge.
   task automatic do_reset();
      @(negedge Hclk);
      Hreset = 1'b1;
      Htrans = T_IDLE; Hreadyin = 1'b1;
      model_reset();
      #1;
      push_exp();
      check_out();
      @(posedge Hclk);
      #2;
      push_exp();
      check_out();
      Hreset = 1'b0;
   endtask

   logic [31:0] addr_pool [8];
   logic [7:0]  cnt_before;

   initial begin
      addr_pool[0] = 32'h8000_0000; addr_pool[1] = 32'h83FF_FFFC;
      addr_pool[2] = 32'h8400_0000; addr_pool[3] = 32'h87FF_FFFF;
      addr_pool[4] = 32'h8800_0000; addr_pool[5] = 32'h8BFF_FFFC;
      addr_pool[6] = 32'h8C00_0000; addr_pool[7] = 32'h7FFF_FFFC;

      Hreset = 1'b1; Hwrite = 1'b0; Hreadyin = 1'b1; Htrans = T_IDLE;
      Haddr = 0; Hwdata = 0; Prdata = 0;
      model_reset();
      do_reset();

      // 1: single NONSEQ write to slave 0
      cycle(T_NSEQ, 1'b1, 32'h8000_0010, 32'h0, 1'b1);
      #1;
      chk("t1_Haddr1", Haddr1, 32'h8000_0010);
      chk("t1_Hwritereg", {31'd0, Hwritereg}, 32'd1);

      // 2: SEQ burst to slave 1, write data one phase behind the address
      cycle(T_NSEQ, 1'b1, 32'h8400_0000, 32'h0, 1'b1);
      cycle(T_SEQ,  1'b1, 32'h8400_0004, 32'hAAAA_0001, 1'b1);
      cycle(T_SEQ,  1'b1, 32'h8400_0008, 32'hBBBB_0002, 1'b1);
      #1;
      chk("t2_Haddr2", Haddr2, 32'h8400_0004);
      chk("t2_Hwdata2", Hwdata2, 32'hAAAA_0001);

      // 4: three wait states mid-burst hold the pipeline
      for (int i = 0; i < 3; i++)
         cycle(T_SEQ, 1'b0, 32'h8400_000C, 32'hDEAD_BEEF, 1'b0);
      #1;
      chk("t4_Haddr1_held", Haddr1, 32'h8400_0008);
      chk("t4_Hwdata1_held", Hwdata1, 32'hBBBB_0002);
      cycle(T_SEQ, 1'b1, 32'h8400_000C, 32'hCCCC_0003, 1'b1);

      // 3: unmapped read, then another unmapped transfer during the second ERROR cycle (ignored)
      cnt_before = err_cnt;
      cycle(T_NSEQ, 1'b0, 32'h9000_0000, 32'h0, 1'b1);
      cycle(T_IDLE, 1'b0, 32'h0, 32'h0, 1'b1);
      cycle(T_NSEQ, 1'b0, 32'h9000_0004, 32'h0, 1'b1);
      cycle(T_IDLE, 1'b0, 32'h0, 32'h0, 1'b1);
      #1;
      chk("t3_err_cnt", {24'd0, err_cnt}, {24'd0, cnt_before} + 32'd1);

      // 5: BUSY/IDLE to slave 2 decode but never qualify
      cycle(T_BUSY, 1'b1, 32'h8800_0000, 32'h0, 1'b1);
      cycle(T_IDLE, 1'b1, 32'h8800_0000, 32'h0, 1'b1);
      cycle(T_BUSY, 1'b0, 32'h9800_0000, 32'h0, 1'b1);
      #1;
      chk("t5_err_cnt", {24'd0, err_cnt}, {24'd0, cnt_before} + 32'd1);

      // 6a: reset while in the first ERROR cycle
      cycle(T_NSEQ, 1'b0, 32'hA000_0000, 32'h0, 1'b1);
      #1;
      chk("t6_in_err1", {30'd0, Hresp}, 32'd1);
      do_reset();

      // Randomised traffic over region boundaries and unmapped neighbours
      for (int i = 0; i < 300; i++)
         cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               addr_pool[$urandom_range(0, 7)], $urandom, ($urandom_range(0, 3) != 0));

      // 6b: counter saturates
      for (int i = 0; i < 260; i++) begin
         cycle(T_NSEQ, 1'b0, 32'h7FFF_FFFC, 32'h0, 1'b1);
         cycle(T_IDLE, 1'b0, 32'h0, 32'h0, 1'b1);
         cycle(T_IDLE, 1'b0, 32'h0, 32'h0, 1'b1);
      end
      #1;
      chk("t6_err_cnt_sat", {24'd0, err_cnt}, 32'h0000_00FF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
